// File: rtl/epu_dma_pkg.sv
// Shared constants, state encodings and the burst sizing helper for the
// EPU DMA master.
package epu_dma_pkg;

  localparam int MAX_BURST  = 16;
  localparam int FIFO_DEPTH = MAX_BURST;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef logic [2:0] dma_state_t;

  localparam dma_state_t ST_IDLE    = 3'd0;
  localparam dma_state_t ST_RD_ADDR = 3'd1;
  localparam dma_state_t ST_RD_DATA = 3'd2;
  localparam dma_state_t ST_WR_ADDR = 3'd3;
  localparam dma_state_t ST_WR_DATA = 3'd4;
  localparam dma_state_t ST_WR_RESP = 3'd5;
  localparam dma_state_t ST_FIN     = 3'd6;

  // Beats for the next burst: the smallest of the words left, the burst cap
  // and the room before the next 4KB page on either side. The page offsets
  // are passed as word indices (address bits [11:2]).
  function automatic logic [4:0] burst_beats(input logic [15:0] max_beats,
                                             input logic [15:0] remaining,
                                             input logic [9:0]  src_word,
                                             input logic [9:0]  dst_word);
    logic [15:0] m;
    logic [15:0] src_room;
    logic [15:0] dst_room;
    src_room = 16'd1024 - {6'd0, src_word};
    dst_room = 16'd1024 - {6'd0, dst_word};
    m = max_beats;
    if (remaining < m) m = remaining;
    if (src_room < m)  m = src_room;
    if (dst_room < m)  m = dst_room;
    return m[4:0];
  endfunction

endpackage

// File: rtl/epu_dma_fifo.sv
// Small synchronous FIFO that holds one read burst until it is written out.
module epu_dma_fifo import epu_dma_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Read/write pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/epu_dma_master.sv
// AXI master DMA: copies a block of words from src to dst as a series of
// read-burst / write-burst pairs, one outstanding transaction at a time.
module epu_dma_master import epu_dma_pkg::*; #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              ID_W      = 4,
  parameter logic [ID_W-1:0] DMA_ID    = ID_W'(4'h2),
  parameter int              MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [15:0]       len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [15:0] MAX_BEATS = 16'(MAX_BURST);

  dma_state_t        state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [15:0]       rem_q;
  logic [3:0]        len_q;
  logic [4:0]        rcnt_q;
  logic [4:0]        wbeat_q;
  logic              err_q;

  logic [4:0]        beats;
  logic [ADDR_W-1:0] src_start;
  logic [ADDR_W-1:0] dst_start;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] src_next;
  logic [ADDR_W-1:0] dst_next;
  logic [15:0]       rem_next;
  logic [4:0]        first_beats;
  logic [4:0]        next_beats;

  logic              fifo_flush;
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              w_pad;
  logic              unused_inputs;

  // len_q holds beats-1 so the AXI len fields read zero out of reset.
  assign beats     = {1'b0, len_q} + 5'd1;
  assign src_start = {src_addr_i[ADDR_W-1:2], 2'b00};
  assign dst_start = {dst_addr_i[ADDR_W-1:2], 2'b00};
  assign step      = {{(ADDR_W-7){1'b0}}, beats, 2'b00};
  assign src_next  = src_q + step;
  assign dst_next  = dst_q + step;
  assign rem_next  = rem_q - {11'd0, beats};

  assign first_beats = burst_beats(MAX_BEATS, len_i, src_start[11:2], dst_start[11:2]);
  assign next_beats  = burst_beats(MAX_BEATS, rem_next, src_next[11:2], dst_next[11:2]);

  // Words beyond the burst length are dropped; a short read is padded with
  // zeros on the write side once every received word has been sent.
  assign fifo_flush = (state_q == ST_IDLE) && start_i;
  assign fifo_push  = rvalid && rready && (rcnt_q < beats);
  assign w_pad      = (wbeat_q >= rcnt_q);
  assign fifo_pop   = wvalid && wready && !w_pad;

  assign arid    = DMA_ID;
  assign araddr  = src_q;
  assign arlen   = len_q;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = (state_q == ST_RD_ADDR);
  assign rready  = (state_q == ST_RD_DATA);

  assign awid    = DMA_ID;
  assign awaddr  = dst_q;
  assign awlen   = len_q;
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;
  assign awvalid = (state_q == ST_WR_ADDR);

  assign wvalid  = (state_q == ST_WR_DATA) && (!fifo_empty || w_pad);
  assign wdata   = (wvalid && !w_pad) ? fifo_head : '0;
  assign wlast   = wvalid && (wbeat_q == {1'b0, len_q});
  assign wstrb   = 4'hF;
  assign bready  = (state_q == ST_WR_RESP);

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_FIN);
  assign err_o   = err_q;

  assign unused_inputs = ^{rid, bid, src_addr_i[1:0], dst_addr_i[1:0], fifo_full};

  epu_dma_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (rdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Transfer FSM with the address, length and beat counters it steers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      rcnt_q  <= '0;
      wbeat_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            err_q <= 1'b0;
            if (len_i == 16'd0) begin
              state_q <= ST_FIN;
            end else begin
              src_q   <= src_start;
              dst_q   <= dst_start;
              rem_q   <= len_i;
              len_q   <= 4'(first_beats - 5'd1);
              rcnt_q  <= '0;
              state_q <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (arready) state_q <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (rvalid) begin
            if (fifo_push) rcnt_q <= rcnt_q + 5'd1;
            if (rresp != AXI_RESP_OKAY) err_q <= 1'b1;
            if (rlast) begin
              if (rcnt_q + 5'd1 != beats) err_q <= 1'b1;
              wbeat_q <= '0;
              state_q <= ST_WR_ADDR;
            end
          end
        end
        ST_WR_ADDR: begin
          if (awready) begin
            wbeat_q <= '0;
            state_q <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (wvalid && wready) begin
            wbeat_q <= wbeat_q + 5'd1;
            if (wlast) state_q <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bvalid) begin
            if (bresp != AXI_RESP_OKAY) err_q <= 1'b1;
            src_q <= src_next;
            dst_q <= dst_next;
            rem_q <= rem_next;
            if (rem_next == 16'd0) begin
              state_q <= ST_FIN;
            end else begin
              len_q   <= 4'(next_beats - 5'd1);
              rcnt_q  <= '0;
              state_q <= ST_RD_ADDR;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
